aes_round_core: RTL and testbench
=================================

Name: aes_round_core

Overview:
- Iterative AES encryption datapath. Generalises the single-pass SubBytes/ShiftRows/MixColumns front-end into a full cipher core.
- Runs the initial AddRoundKey and then NR rounds.
- Takes round keys from an external key store through an indexed lookup.
- S-box width is configurable (LANES bytes per cycle), trading area for latency.
- Has valid/ready handshakes on both input and output.

Parameters:
- NR, 10, number of rounds. Legal values: 10, 12, 14 (AES-128/192/256).
- LANES, 16, S-box instances used per cycle. Legal values: 1, 2, 4, 8, 16. S = 16/LANES is the number of SubBytes cycles per round.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  input block valid
- in_ready  out  1  core can accept a block
- in_block  in  128  plaintext. Byte 0 = [127:120]. Column-major state, FIPS-197 order.
- rk_idx  out  4  round-key index requested this cycle
- rk  in  128  round key for rk_idx. Combinational lookup, must be valid in the same cycle.
- out_valid  out  1  ciphertext valid
- out_ready  in  1  consumer accepts ciphertext
- out_block  out  128  ciphertext, same byte order as in_block
- busy  out  1  high in any state other than IDLE

Behaviour:
- FSM states: IDLE, SUB, MIX, DONE. Registers: st[127:0], round[3:0], lane counter lc.
- Reset (synchronous) values: FSM=IDLE, st=0, round=0, lc=0, out_valid=0, out_block=0, in_ready=1, busy=0.
- Reset asserted mid-operation aborts the block silently. No out_valid is produced for it.
- rk_idx: 0 in IDLE, round in SUB/MIX, NR in DONE. Driven from registers only, so it is glitch-free.
- IDLE:
  - in_ready=1.
  - On in_valid: st <= in_block ^ rk (rk_idx=0), round <= 1, lc <= 0, go to SUB.
- SUB:
  - Each cycle, bytes lc*LANES .. lc*LANES+LANES-1 of st are replaced by their S-box values.
  - lc increments. After S cycles, lc wraps to 0 and the FSM goes to MIX.
  - Uses the existing single-byte S-box block, LANES instances, muxed by lc.
- MIX:
  - One cycle: st <= MixColumns(ShiftRows(st)) ^ rk.
  - When round==NR, MixColumns is bypassed: st <= ShiftRows(st) ^ rk.
  - If round==NR go to DONE, else round++ and go to SUB.
- DONE:
  - out_valid=1, out_block=st. Both are held stable until out_ready.
  - On out_ready: out_valid <= 0, go to IDLE.
- Latency: the accept edge is E0. out_valid rises after edge E0 + NR*(S+1).
  - NR=10, LANES=16: 20 cycles.
  - NR=10, LANES=4: 50 cycles.
- in_ready is 0 in SUB, MIX and DONE (default build). in_valid in those states is ignored and nothing is queued.
- out_ready outside DONE has no effect.
- MixColumns uses GF(2^8) xtime with reduction polynomial 0x11B. All arithmetic is 8-bit XOR, with no carries.
- ShiftRows: row r of the column-major state rotates left by r.
- Illegal NR or LANES: compile-time error via a generate-time check.

Optional Feature:
- Macro: AES_ROUND_CORE_EARLY_ACCEPT_EN.
- Enabled:
  - In DONE, in_ready = out_ready.
  - When out_valid & out_ready & in_valid are all high in the same cycle, the new block is loaded (st <= in_block ^ rk with rk_idx forced to 0 that cycle, round <= 1) and the FSM goes directly to SUB.
  - Throughput: one block per NR*(S+1)+1 cycles.
- Disabled:
  - in_ready=0 in DONE.
  - At least one IDLE cycle separates consecutive blocks.

Test Plan:
- FIPS-197 C.1, NR=10, LANES=16:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f expanded in a bench ROM, pt 00112233445566778899aabbccddeeff.
  - Response: out_block = 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 20 cycles after accept.
- Same vector with LANES=4:
  - Response: identical ciphertext, out_valid exactly 50 cycles after accept.
  - rk_idx sequence 0,1,1,1,1,1,2,… observed.
- NR=14, FIPS-197 C.3:
  - Stimulus: key 000102…1e1f.
  - Response: ciphertext 8ea2b7ca516745bfeafc49904b496089, latency 28 cycles (LANES=16).
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles in DONE.
  - Response: out_valid=1 and out_block unchanged for all 5 cycles, in_ready=0 (macro off). Handshake completes on cycle 6.
- Reset mid-operation:
  - Stimulus: assert reset for 1 cycle, 7 cycles after accept.
  - Response: next cycle in_ready=1, busy=0, out_valid never rises. A following C.1 block still produces the correct ciphertext.
- Back-to-back with macro on:
  - Stimulus: two C.1 blocks with in_valid held high, out_ready=1.
  - Response: second block accepted on the same edge as the first output handshake. Second out_valid 21 cycles after the first.

Source files
------------

// File: rtl/aes_round_core.sv
// Iterative AES encryption core: initial AddRoundKey, then NR rounds with LANES S-boxes per SubBytes cycle.
// Define AES_ROUND_CORE_EARLY_ACCEPT_EN to let DONE hand off and accept the next block on the same edge.

module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] s
);
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gfMul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] acc;
        p   = x;
        acc = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (y[i[2:0]]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;

    // Inverse is a^254 via an addition chain; zero maps to zero as required.
    always_comb begin
        x2   = gfMul(a, a);
        x3   = gfMul(x2, a);
        x6   = gfMul(x3, x3);
        x12  = gfMul(x6, x6);
        x15  = gfMul(x12, x3);
        x30  = gfMul(x15, x15);
        x60  = gfMul(x30, x30);
        x120 = gfMul(x60, x60);
        x240 = gfMul(x120, x120);
        x252 = gfMul(x240, x12);
        inv  = gfMul(x252, x2);
        s    = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

module aes_round_core #(
    parameter int NR    = 10,
    parameter int LANES = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_block,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_block,
    output logic         busy
);
    localparam int S   = 16 / LANES;
    localparam int LCW = (S > 1) ? $clog2(S) : 1;

    typedef logic [0:15][7:0] state_t;
    typedef enum logic [1:0] {IDLE, SUB, MIX, DONE} fsm_t;

    generate
        if (!(NR == 10 || NR == 12 || NR == 14)) begin : gBadNr
            $error("aes_round_core: NR must be 10, 12 or 14");
        end
        if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : gBadLanes
            $error("aes_round_core: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    fsm_t           state, stateNext;
    state_t         st, stNext, subSt, sr, mc;
    logic [3:0]     round, roundNext;
    logic [LCW-1:0] lc, lcNext;
    logic           outValidNext;
    logic [127:0]   outBlockNext;
    logic           lastRound;
    logic [7:0]     subIn  [LANES];
    logic [7:0]     subOut [LANES];

    assign lastRound = (round == 4'(NR));

    // Lane j of the S-box bank serves byte lc*LANES+j of the state.
    for (genvar j = 0; j < LANES; j++) begin : gLane
        assign subIn[j] = st[4'(32'(lc) * LANES + j)];
        aes_sbox uSbox (.a(subIn[j]), .s(subOut[j]));
    end

    for (genvar b = 0; b < 16; b++) begin : gByte
        assign subSt[b] = (32'(lc) == b / LANES) ? subOut[b % LANES] : st[b];
    end

    for (genvar c = 0; c < 4; c++) begin : gCol
        for (genvar r = 0; r < 4; r++) begin : gRow
            assign sr[4*c+r] = st[4*((c+r)%4)+r];
        end
        assign mc[4*c+0] = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
        assign mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
        assign mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
        assign mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
    end

    always_comb begin
        rk_idx = '0;
        case (state)
            SUB, MIX: rk_idx = round;
            DONE:     rk_idx = 4'(NR);
            default:  rk_idx = '0;
        endcase
`ifdef AES_ROUND_CORE_EARLY_ACCEPT_EN
        if (state == DONE && out_ready && in_valid) rk_idx = '0;
`endif
    end

    always_comb begin
        stateNext    = state;
        stNext       = st;
        roundNext    = round;
        lcNext       = lc;
        outValidNext = out_valid;
        outBlockNext = out_block;
        in_ready     = 1'b0;
        busy         = (state != IDLE);
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    stNext    = in_block ^ rk;
                    roundNext = 4'd1;
                    lcNext    = '0;
                    stateNext = SUB;
                end
            end
            SUB: begin
                stNext = subSt;
                if (lc == LCW'(S - 1)) begin
                    lcNext    = '0;
                    stateNext = MIX;
                end else begin
                    lcNext = lc + 1'b1;
                end
            end
            MIX: begin
                stNext = (lastRound ? sr : mc) ^ rk;
                if (lastRound) begin
                    stateNext    = DONE;
                    outValidNext = 1'b1;
                    outBlockNext = stNext;
                end else begin
                    roundNext = round + 4'd1;
                    stateNext = SUB;
                end
            end
            DONE: begin
`ifdef AES_ROUND_CORE_EARLY_ACCEPT_EN
                in_ready = out_ready;
`endif
                if (out_ready) begin
                    outValidNext = 1'b0;
                    stateNext    = IDLE;
`ifdef AES_ROUND_CORE_EARLY_ACCEPT_EN
                    if (in_valid) begin
                        stNext    = in_block ^ rk;
                        roundNext = 4'd1;
                        lcNext    = '0;
                        stateNext = SUB;
                    end
`endif
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            st        <= '0;
            round     <= '0;
            lc        <= '0;
            out_valid <= 1'b0;
            out_block <= '0;
        end else begin
            state     <= stateNext;
            st        <= stNext;
            round     <= roundNext;
            lc        <= lcNext;
            out_valid <= outValidNext;
            out_block <= outBlockNext;
        end
    end
endmodule

// File: tb/tb_aes_round_core.sv
// Bench for aes_round_core: three instances (NR10/L16, NR10/L4, NR14/L16) against FIPS-197 vectors and a byte-matrix AES model.
module tb_aes_round_core;
    localparam int ND = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic         inValid  [ND];
    logic         inReady  [ND];
    logic         outValid [ND];
    logic         outReady [ND];
    logic         busy     [ND];
    logic [127:0] inBlock  [ND];
    logic [127:0] rk       [ND];
    logic [127:0] outBlock [ND];
    logic [3:0]   rkIdx    [ND];
    logic [127:0] rkRom    [ND][16];
    logic [7:0]   sboxTab  [256];
    int           rkLog[$];
    int           nChecks = 0;
    int           nFail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : gDut
        aes_round_core #(.NR((g == 2) ? 14 : 10), .LANES((g == 1) ? 4 : 16)) dut (
            .clk(clk), .reset(reset),
            .in_valid(inValid[g]), .in_ready(inReady[g]), .in_block(inBlock[g]),
            .rk_idx(rkIdx[g]), .rk(rk[g]),
            .out_valid(outValid[g]), .out_ready(outReady[g]), .out_block(outBlock[g]),
            .busy(busy[g])
        );
        assign rk[g] = rkRom[g][rkIdx[g]];
    end

    function automatic int nrOf(input int d);
        return (d == 2) ? 14 : 10;
    endfunction

    function automatic int sOf(input int d);
        return (d == 1) ? 4 : 1;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Polynomial product then long division by 0x11B.
    function automatic logic [7:0] gfMulRef(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ ({8'h00, a} << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    task automatic buildSbox();
        logic [7:0] inv, b, c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = '0;
            for (int y = 1; y < 256; y++) if (gfMulRef(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                b[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            sboxTab[x] = b;
        end
    endtask

    function automatic logic [31:0] subWord(input logic [31:0] w);
        return {sboxTab[w[31:24]], sboxTab[w[23:16]], sboxTab[w[15:8]], sboxTab[w[7:0]]};
    endfunction

    // key is left-aligned: a 128-bit key occupies [255:128].
    task automatic expandKey(input int d, input logic [255:0] key, input int nk);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rcon [16];
        int          nw;
        rcon[1] = 8'h01;
        for (int j = 2; j < 16; j++) rcon[j] = gfMulRef(rcon[j-1], 8'h02);
        nw = 4 * (nrOf(d) + 1);
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < nw; i++) begin
            t = w[i-1];
            if (i % nk == 0) t = subWord({t[23:0], t[31:24]}) ^ {rcon[i/nk], 24'h0};
            else if (nk > 6 && i % nk == 4) t = subWord(t);
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 16; r++)
            rkRom[d][r] = (r <= nrOf(d)) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
    endtask

    function automatic logic [127:0] modelEncrypt(input int d, input logic [127:0] pt);
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [7:0]   coef [4];
        logic [127:0] k, o;
        coef = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int c = 0; c < 4; c++) for (int r = 0; r < 4; r++) s[r][c] = pt[127 - 8*(4*c+r) -: 8];
        for (int rnd = 0; rnd <= nrOf(d); rnd++) begin
            if (rnd > 0) begin
                for (int c = 0; c < 4; c++) for (int r = 0; r < 4; r++) t[r][c] = sboxTab[s[r][(c+r)%4]];
                for (int c = 0; c < 4; c++) for (int r = 0; r < 4; r++) begin
                    if (rnd == nrOf(d)) s[r][c] = t[r][c];
                    else begin
                        s[r][c] = '0;
                        for (int q = 0; q < 4; q++) s[r][c] = s[r][c] ^ gfMulRef(coef[(q-r+4)%4], t[q][c]);
                    end
                end
            end
            k = rkRom[d][rnd];
            for (int c = 0; c < 4; c++) for (int r = 0; r < 4; r++) s[r][c] = s[r][c] ^ k[127 - 8*(4*c+r) -: 8];
        end
        o = '0;
        for (int c = 0; c < 4; c++) for (int r = 0; r < 4; r++) o = {o[119:0], s[r][c]};
        return o;
    endfunction

    // One block through instance d; optional junk in_valid mid-run and hold cycles of backpressure.
    task automatic runBlock(input int d, input logic [127:0] pt, input int hold, input bit junk,
                            output logic [127:0] ct, output int lat);
        @(negedge clk);
        check("in_ready before accept", inReady[d], 1'b1);
        inValid[d] = 1'b1;
        inBlock[d] = pt;
        rkLog.delete();
        rkLog.push_back(int'(rkIdx[d]));
        @(posedge clk);
        @(negedge clk);
        inValid[d] = 1'b0;
        rkLog.push_back(int'(rkIdx[d]));
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (outValid[d]) begin
                lat = k;
                break;
            end
            if (junk && k == 3) begin
                check("in_ready while busy", inReady[d], 1'b0);
                inValid[d] = 1'b1;
                inBlock[d] = ~pt;
            end
            if (junk && k == 4) inValid[d] = 1'b0;
            rkLog.push_back(int'(rkIdx[d]));
        end
        ct = outBlock[d];
        check("rk_idx in DONE", rkIdx[d], 128'(nrOf(d)));
        for (int h = 0; h < hold; h++) begin
            check("backpressure out_valid", outValid[d], 1'b1);
            check("backpressure out_block", outBlock[d], ct);
            check("backpressure in_ready", inReady[d], 1'b0);
            @(negedge clk);
        end
        outReady[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        outReady[d] = 1'b0;
        check("out_valid after handshake", outValid[d], 1'b0);
        check("busy after handshake", busy[d], 1'b0);
        check("in_ready after handshake", inReady[d], 1'b1);
    endtask

    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_C3 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [255:0] KEY_C1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [127:0] ct, ct2, pt;
        logic [255:0] key;
        int           lat, firstBad, t1, t2, seen;
        int           expSeq[$];

        for (int d = 0; d < ND; d++) begin
            inValid[d] = 1'b0; outReady[d] = 1'b0; inBlock[d] = '0;
        end
        reset = 1'b1;
        buildSbox();
        expandKey(0, KEY_C1, 4);
        expandKey(1, KEY_C1, 4);
        expandKey(2, KEY_C3, 8);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int d = 0; d < ND; d++) begin
            check("reset in_ready", inReady[d], 1'b1);
            check("reset busy", busy[d], 1'b0);
            check("reset out_valid", outValid[d], 1'b0);
            check("reset out_block", outBlock[d], '0);
            check("reset rk_idx", rkIdx[d], '0);
        end

        runBlock(0, PT_C, 0, 1'b0, ct, lat);
        check("C.1 L16 ciphertext", ct, CT_C1);
        check("C.1 L16 latency", lat, 20);

        runBlock(1, PT_C, 0, 1'b0, ct, lat);
        check("C.1 L4 ciphertext", ct, CT_C1);
        check("C.1 L4 latency", lat, 50);
        expSeq.delete();
        expSeq.push_back(0);
        for (int r = 1; r <= nrOf(1); r++) for (int j = 0; j <= sOf(1); j++) expSeq.push_back(r);
        firstBad = -1;
        for (int i = 0; i < expSeq.size(); i++)
            if (firstBad < 0 && (i >= rkLog.size() || rkLog[i] != expSeq[i])) firstBad = i;
        if (firstBad < 0 && rkLog.size() != expSeq.size()) firstBad = expSeq.size();
        check("L4 rk_idx sequence first bad index", firstBad, -1);

        runBlock(2, PT_C, 0, 1'b0, ct, lat);
        check("C.3 ciphertext", ct, CT_C3);
        check("C.3 latency", lat, 28);

        runBlock(0, PT_C, 5, 1'b0, ct, lat);
        check("backpressure ciphertext", ct, CT_C1);

        runBlock(1, PT_C, 1, 1'b1, ct, lat);
        check("ignored in_valid ciphertext", ct, CT_C1);

        // Abort a block with a one-cycle reset seven edges after accept.
        @(negedge clk);
        inValid[0] = 1'b1;
        inBlock[0] = PT_C;
        @(posedge clk);
        @(negedge clk);
        inValid[0] = 1'b0;
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("post-abort in_ready", inReady[0], 1'b1);
        check("post-abort busy", busy[0], 1'b0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (outValid[0]) seen = 1;
        end
        check("aborted block out_valid", seen, 0);
        runBlock(0, PT_C, 0, 1'b0, ct, lat);
        check("after abort ciphertext", ct, CT_C1);

        for (int d = 0; d < ND; d++) begin
            for (int n = 0; n < 3; n++) begin
                key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                expandKey(d, key, (d == 2) ? 8 : 4);
                pt = {$urandom, $urandom, $urandom, $urandom};
                runBlock(d, pt, $urandom_range(0, 2), n[0], ct, lat);
                check("random ciphertext", ct, modelEncrypt(d, pt));
                check("random latency", lat, nrOf(d) * (sOf(d) + 1));
            end
        end

`ifdef AES_ROUND_CORE_EARLY_ACCEPT_EN
        expandKey(0, KEY_C1, 4);
        @(negedge clk);
        inValid[0] = 1'b1;
        inBlock[0] = PT_C;
        outReady[0] = 1'b1;
        @(posedge clk);
        t1 = -1;
        t2 = -1;
        for (int k = 0; k <= 100 && t2 < 0; k++) begin
            @(negedge clk);
            if (outValid[0]) begin
                if (t1 < 0) begin
                    t1 = k;
                    ct = outBlock[0];
                    check("early accept in_ready", inReady[0], 1'b1);
                end else begin
                    t2 = k;
                    ct2 = outBlock[0];
                    inValid[0] = 1'b0;
                end
            end
        end
        @(negedge clk);
        outReady[0] = 1'b0;
        check("b2b first latency", t1, 20);
        check("b2b spacing", t2 - t1, 21);
        check("b2b first ciphertext", ct, CT_C1);
        check("b2b second ciphertext", ct2, CT_C1);
        check("b2b idle after", busy[0], 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
